// File: rtl/muxn_rr_sel_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muxn_rr_sel_if : producer/consumer bundle for the N:1 registered mux |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
interface muxn_rr_sel_if #(
    parameter int N  = 4,
    parameter int W  = 1,
    parameter int SW = (N > 1) ? $clog2(N) : 1
);
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  sel;
    logic           mode;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_ch;
    logic [15:0]    stat_count;

    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_valid, out_ch, stat_count
    );

    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_valid, out_ch, stat_count
    );
endinterface
`default_nettype wire

// File: rtl/muxn_rr_sel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muxn_rr_sel : N-channel registered mux, fixed-select or round-robin |
// | Optional transfer counter built when MUXN_STATS_EN is defined.       |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module muxn_rr_sel #(
    parameter int N  = 4,
    parameter int W  = 1,
    parameter int SW = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    muxn_rr_sel_if.slave   bus
);
    localparam logic [SW:0]   c_n_ext   = (SW+1)'(N);
    localparam logic [SW-1:0] c_rr_init = SW'(N-1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   data_q, data_d;
    logic [SW-1:0]  ch_q, ch_d;
    logic [SW-1:0]  rr_ptr_q, rr_ptr_d;

    logic [W-1:0]   w_ch_data [N];
    logic [SW:0]    w_sel_ext;
    logic           w_can_load;
    logic           w_grant_valid;
    logic [SW-1:0]  w_grant;
    logic [N-1:0]   w_ready;
    logic           w_xfer_in;
    logic           w_xfer_out;
    int             w_dist;
    int             w_best;

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_unpack
            assign w_ch_data[k] = bus.in_data[k*W +: W];
        end
    endgenerate

    assign w_sel_ext  = {1'b0, bus.sel};
    // Hold off every producer while rst is high so no word appears accepted at a reset edge.
    assign w_can_load = !rst && ((state_q == ST_EMPTY) || bus.out_ready);
    assign w_xfer_in  = w_can_load && w_grant_valid;
    assign w_xfer_out = (state_q == ST_FULL) && bus.out_ready;

    // Round-robin picks the valid channel at the smallest distance after rr_ptr.
    always_comb begin
        w_grant       = '0;
        w_grant_valid = 1'b0;
        w_best        = N;
        w_dist        = 0;
        if (!bus.mode) begin
            if ((w_sel_ext < c_n_ext) && bus.in_valid[bus.sel]) begin
                w_grant       = bus.sel;
                w_grant_valid = 1'b1;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                w_dist = (i + N - 1 - int'(rr_ptr_q)) % N;
                if (bus.in_valid[i] && (w_dist < w_best)) begin
                    w_best        = w_dist;
                    w_grant       = SW'(i);
                    w_grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_xfer_in) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        ch_d     = ch_q;
        rr_ptr_d = rr_ptr_q;
        if (w_xfer_in) begin
            state_d = ST_FULL;
            data_d  = w_ch_data[w_grant];
            ch_d    = w_grant;
            if (bus.mode) begin
                rr_ptr_d = w_grant;
            end
        end else if (w_xfer_out) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            data_q   <= '0;
            ch_q     <= '0;
            rr_ptr_q <= c_rr_init;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            ch_q     <= ch_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_data  = data_q;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_ch    = ch_q;

`ifdef MUXN_STATS_EN
    logic [15:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (w_xfer_out && (stat_q != 16'hFFFF)) begin
            stat_d = stat_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= 16'h0000;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign bus.stat_count = stat_q;
`else
    assign bus.stat_count = 16'h0000;
`endif
endmodule
`default_nettype wire

// File: tb/tb_muxn_rr_sel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_muxn_rr_sel : directed bench with a reference model of the mux   |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module tb_muxn_rr_sel;
`ifdef MUXN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    muxn_rr_sel_if #(.N(4), .W(8), .SW(2)) bus ();
    muxn_rr_sel    #(.N(4), .W(8), .SW(2)) dut  (.clk(clk), .rst(rst), .bus(bus));

    muxn_rr_sel_if #(.N(3), .W(8), .SW(2)) bus3 ();
    muxn_rr_sel    #(.N(3), .W(8), .SW(2)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: registered word, round-robin pointer, transfer count.
    bit       m_valid;
    bit [7:0] m_data;
    int       m_ch;
    int       m_rr;
    int       m_cnt;

    initial begin
        m_valid = 0; m_data = 0; m_ch = 0; m_rr = 3; m_cnt = 0;
    end

    always @(negedge clk) begin
        int   g;
        bit   gv;
        bit   can_load;
        logic [3:0] exp_ready;
        g = 0;
        gv = 0;
        if (!bus.mode) begin
            if (int'(bus.sel) < 4 && bus.in_valid[bus.sel]) begin
                gv = 1; g = int'(bus.sel);
            end
        end else begin
            for (int i = 1; i <= 4; i++) begin
                if (!gv && bus.in_valid[(m_rr + i) % 4]) begin
                    gv = 1; g = (m_rr + i) % 4;
                end
            end
        end
        can_load  = !rst && (!m_valid || bus.out_ready);
        exp_ready = (can_load && gv) ? (4'b0001 << g) : 4'b0000;

        chk("model in_ready",   32'(bus.in_ready),   32'(exp_ready));
        chk("model out_valid",  32'(bus.out_valid),  32'(m_valid));
        chk("model out_data",   32'(bus.out_data),   32'(m_data));
        chk("model out_ch",     32'(bus.out_ch),     32'(m_ch));
        chk("model stat_count", 32'(bus.stat_count), 32'(m_cnt));

        if (rst) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_rr = 3; m_cnt = 0;
        end else begin
            if (m_valid && bus.out_ready && STATS && m_cnt < 65535) m_cnt++;
            if (can_load && gv) begin
                m_valid = 1;
                m_data  = bus.in_data[g*8 +: 8];
                m_ch    = g;
                if (bus.mode) m_rr = g;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 0;
            end
        end
    end

    int seq_a [6] = '{0, 1, 2, 3, 0, 1};
    int seq_b [4] = '{1, 3, 1, 3};

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'hF; bus.out_ready = 1'b1;
        bus.in_data = {8'h3C, 8'hA5, 8'h22, 8'h11};
        bus3.mode = 1'b0; bus3.sel = 2'd3; bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
        bus3.in_data = {8'h77, 8'h66, 8'h55};

        // Reset with inputs active
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid", 32'(bus.out_valid), 0);
        chk("rst out_data",  32'(bus.out_data),  0);
        chk("rst out_ch",    32'(bus.out_ch),    0);
        chk("rst in_ready",  32'(bus.in_ready),  0);
        chk("rst stat",      32'(bus.stat_count), 0);
        step();
        rst = 1'b0;

        // Fixed select
        @(negedge clk);
        chk("fixed in_ready sel2", 32'(bus.in_ready), 32'h4);
        step();
        bus.sel = 2'd3;
        @(negedge clk);
        chk("fixed out_data A5", 32'(bus.out_data), 32'hA5);
        chk("fixed out_ch 2",    32'(bus.out_ch),   2);
        chk("fixed in_ready sel3", 32'(bus.in_ready), 32'h8);
        step();
        @(negedge clk);
        chk("fixed out_data 3C", 32'(bus.out_data), 32'h3C);
        chk("fixed out_ch 3",    32'(bus.out_ch),   3);

        // Round-robin, all channels valid, starting with a register still full (reset drops it)
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.mode = 1'b1;
        bus.in_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rr seq all", 32'(bus.out_ch), 32'(seq_a[i]));
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rr seq 1010", 32'(bus.out_ch), 32'(seq_b[i]));
        end

        // Backpressure
        step();
        bus.in_valid = 4'h0;
        step();
        bus.mode = 1'b0; bus.sel = 2'd1; bus.in_valid = 4'hF; bus.out_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            bus.in_data = {$urandom()};
            bus.sel = 2'($urandom_range(0, 3));
            bus.mode = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("bp out_data", 32'(bus.out_data), 32'h22);
            chk("bp out_ch",   32'(bus.out_ch),   1);
            chk("bp out_valid", 32'(bus.out_valid), 1);
            chk("bp in_ready", 32'(bus.in_ready), 0);
            step();
        end
        bus.mode = 1'b0; bus.sel = 2'd2; bus.out_ready = 1'b1;
        bus.in_data = {8'h3C, 8'h5A, 8'h22, 8'h11};
        @(negedge clk);
        chk("release in_ready", 32'(bus.in_ready), 32'h4);
        step();
        @(negedge clk);
        chk("release out_valid", 32'(bus.out_valid), 1);
        chk("release out_data",  32'(bus.out_data),  32'h5A);
        chk("release out_ch",    32'(bus.out_ch),    2);

        // Idle and out-of-range select
        step();
        bus.in_valid = 4'h0;
        @(negedge clk);
        chk("idle in_ready", 32'(bus.in_ready), 0);
        chk("oor in_ready", 32'(bus3.in_ready), 0);
        chk("oor out_valid", 32'(bus3.out_valid), 0);
        step();
        @(negedge clk);
        chk("idle drained", 32'(bus.out_valid), 0);
        step();
        bus3.sel = 2'd0;
        step();
        bus3.sel = 2'd3;
        @(negedge clk);
        chk("n3 out_valid", 32'(bus3.out_valid), 1);
        chk("n3 out_data",  32'(bus3.out_data),  32'h55);
        chk("n3 in_ready oor", 32'(bus3.in_ready), 0);
        step();
        @(negedge clk);
        chk("n3 drained", 32'(bus3.out_valid), 0);

        // Mode 0 -> 1 resumes from the last round-robin grant
        bus.mode = 1'b1; bus.in_valid = 4'hF;
        repeat (3) step();

        // Transfer counter
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("stat after 10", 32'(bus.stat_count), STATS ? 10 : 0);
`ifdef MUXN_STATS_EN
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("stat saturated", 32'(bus.stat_count), 32'hFFFF);
`endif
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
